// File: rtl/wb_regfile_if.sv
// MEM/WB writeback and ID read-port bundle for wb_regfile.
// master drives MEM/WB fields and read indices; slave is the register file.
interface wb_regfile_if;
    logic        wb_reg_write;
    logic        wb_mem_reg;
    logic [31:0] wb_read_data_mem;
    logic [31:0] wb_alu_result;
    logic [4:0]  wb_write_reg;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;
    logic [31:0] wb_data;
    logic        wb_we;

    modport master (
        output wb_reg_write, wb_mem_reg, wb_read_data_mem, wb_alu_result, wb_write_reg,
        output rd_addr1, rd_addr2,
        input  rd_data1, rd_data2, wb_data, wb_we
    );

    modport slave (
        input  wb_reg_write, wb_mem_reg, wb_read_data_mem, wb_alu_result, wb_write_reg,
        input  rd_addr1, rd_addr2,
        output rd_data1, rd_data2, wb_data, wb_we
    );
endinterface

// File: rtl/wb_regfile.sv
// Writeback mux and 32x32 architectural register file with two combinational read ports.
// Define WB_BYPASS_EN for a write-first WB->ID bypass; default build has no bypass.
module wb_regfile (
    input  logic         clk,
    input  logic         rst,
    wb_regfile_if.slave  bus
);
    logic [31:0] regs_q [32];
    logic [31:0] wb_data;
    logic        wb_we;

    always_comb begin
        wb_data = bus.wb_mem_reg ? bus.wb_read_data_mem : bus.wb_alu_result;
        wb_we   = bus.wb_reg_write && (bus.wb_write_reg != 5'd0);
    end

    assign bus.wb_data = wb_data;
    assign bus.wb_we   = wb_we;

    // Reset clears every entry in one edge and takes priority over a pending write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'h0;
            end
        end else if (wb_we) begin
            regs_q[bus.wb_write_reg] <= wb_data;
        end
    end

    always_comb begin
        bus.rd_data1 = regs_q[bus.rd_addr1];
        bus.rd_data2 = regs_q[bus.rd_addr2];
`ifdef WB_BYPASS_EN
        if (!rst && wb_we && (bus.rd_addr1 == bus.wb_write_reg)) begin
            bus.rd_data1 = wb_data;
        end
        if (!rst && wb_we && (bus.rd_addr2 == bus.wb_write_reg)) begin
            bus.rd_data2 = wb_data;
        end
`endif
        // $0 reads as zero regardless of storage or bypass.
        if (bus.rd_addr1 == 5'd0) begin
            bus.rd_data1 = 32'h0;
        end
        if (bus.rd_addr2 == 5'd0) begin
            bus.rd_data2 = 32'h0;
        end
    end
endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile.
module tb_wb_regfile;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    wb_regfile_if bus ();

    wb_regfile dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs are changed here, checks #1 later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wb_reg_write     = 1'b0;
        bus.wb_mem_reg       = 1'b0;
        bus.wb_read_data_mem = 32'h0;
        bus.wb_alu_result    = 32'h0;
        bus.wb_write_reg     = 5'd0;
    endtask

    task automatic write_alu(input logic [4:0] idx, input logic [31:0] val);
        bus.wb_reg_write  = 1'b1;
        bus.wb_mem_reg    = 1'b0;
        bus.wb_alu_result = val;
        bus.wb_write_reg  = idx;
        step();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.rd_addr1 = 5'd1;
        bus.rd_addr2 = 5'd31;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.rd_data1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_init_rd1: got %h want %h", bus.rd_data1, 32'h0);
        end
        checks++;
        if (bus.rd_data2 !== 32'h0) begin
            errors++;
            $display("FAIL reset_init_rd2: got %h want %h", bus.rd_data2, 32'h0);
        end
        checks++;
        if (bus.wb_we !== 1'b0 || bus.wb_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_idle_wb: got we=%b data=%h want we=0 data=0",
                     bus.wb_we, bus.wb_data);
        end
        write_alu(5'd5, 32'hDEADBEEF);
        bus.rd_addr1 = 5'd5;
        #1;
        checks++;
        if (bus.rd_data1 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL reset_prewrite_r5: got %h want %h", bus.rd_data1, 32'hDEADBEEF);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.rd_data1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_clears_r5: got %h want %h", bus.rd_data1, 32'h0);
        end
    endtask

    task automatic test_wb_mux();
        bus.wb_reg_write     = 1'b1;
        bus.wb_mem_reg       = 1'b1;
        bus.wb_read_data_mem = 32'h1234_5678;
        bus.wb_alu_result    = 32'hFFFF_0000;
        bus.wb_write_reg     = 5'd9;
        #1;
        checks++;
        if (bus.wb_data !== 32'h1234_5678 || bus.wb_we !== 1'b1) begin
            errors++;
            $display("FAIL mux_load: got data=%h we=%b want data=12345678 we=1",
                     bus.wb_data, bus.wb_we);
        end
        step();
        bus.wb_mem_reg   = 1'b0;
        bus.wb_write_reg = 5'd10;
        #1;
        checks++;
        if (bus.wb_data !== 32'hFFFF_0000) begin
            errors++;
            $display("FAIL mux_alu: got %h want %h", bus.wb_data, 32'hFFFF_0000);
        end
        step();
        idle_inputs();
        bus.rd_addr1 = 5'd9;
        bus.rd_addr2 = 5'd10;
        #1;
        checks++;
        if (bus.rd_data1 !== 32'h1234_5678) begin
            errors++;
            $display("FAIL mux_r9: got %h want %h", bus.rd_data1, 32'h1234_5678);
        end
        checks++;
        if (bus.rd_data2 !== 32'hFFFF_0000) begin
            errors++;
            $display("FAIL mux_r10: got %h want %h", bus.rd_data2, 32'hFFFF_0000);
        end
    endtask

    task automatic test_zero_reg();
        bus.wb_reg_write  = 1'b1;
        bus.wb_mem_reg    = 1'b0;
        bus.wb_alu_result = 32'hA5A5A5A5;
        bus.wb_write_reg  = 5'd0;
        bus.rd_addr1      = 5'd0;
        bus.rd_addr2      = 5'd0;
        #1;
        checks++;
        if (bus.wb_we !== 1'b0) begin
            errors++;
            $display("FAIL zero_we: got %b want %b", bus.wb_we, 1'b0);
        end
        checks++;
        if (bus.rd_data1 !== 32'h0) begin
            errors++;
            $display("FAIL zero_same_cycle: got %h want %h", bus.rd_data1, 32'h0);
        end
        step();
        idle_inputs();
        #1;
        checks++;
        if (bus.rd_data1 !== 32'h0 || bus.rd_data2 !== 32'h0) begin
            errors++;
            $display("FAIL zero_next_cycle: got %h/%h want 0/0", bus.rd_data1, bus.rd_data2);
        end
    endtask

    task automatic test_same_cycle_rw();
        write_alu(5'd7, 32'h1);
        bus.wb_reg_write  = 1'b1;
        bus.wb_alu_result = 32'h2;
        bus.wb_write_reg  = 5'd7;
        bus.rd_addr1      = 5'd7;
        bus.rd_addr2      = 5'd9;
        #1;
        checks++;
`ifdef WB_BYPASS_EN
        if (bus.rd_data1 !== 32'h2) begin
            errors++;
            $display("FAIL rw_bypass: got %h want %h", bus.rd_data1, 32'h2);
        end
`else
        if (bus.rd_data1 !== 32'h1) begin
            errors++;
            $display("FAIL rw_old: got %h want %h", bus.rd_data1, 32'h1);
        end
`endif
        checks++;
        if (bus.rd_data2 !== 32'h1234_5678) begin
            errors++;
            $display("FAIL rw_other_port: got %h want %h", bus.rd_data2, 32'h1234_5678);
        end
        step();
        idle_inputs();
        #1;
        checks++;
        if (bus.rd_data1 !== 32'h2) begin
            errors++;
            $display("FAIL rw_next: got %h want %h", bus.rd_data1, 32'h2);
        end
    endtask

    task automatic test_reset_collide();
        rst = 1'b1;
        bus.wb_reg_write  = 1'b1;
        bus.wb_alu_result = 32'h77;
        bus.wb_write_reg  = 5'd3;
        bus.rd_addr1      = 5'd3;
        bus.rd_addr2      = 5'd3;
        #1;
        checks++;
        if (bus.rd_data1 !== 32'h0 || bus.rd_data2 !== 32'h0) begin
            errors++;
            $display("FAIL collide_during: got %h/%h want 0/0", bus.rd_data1, bus.rd_data2);
        end
        step();
        rst = 1'b0;
        idle_inputs();
        bus.rd_addr2 = 5'd7;
        #1;
        checks++;
        if (bus.rd_data1 !== 32'h0) begin
            errors++;
            $display("FAIL collide_after_r3: got %h want %h", bus.rd_data1, 32'h0);
        end
        checks++;
        if (bus.rd_data2 !== 32'h0) begin
            errors++;
            $display("FAIL collide_after_r7: got %h want %h", bus.rd_data2, 32'h0);
        end
    endtask

    task automatic test_dual_port();
        write_alu(5'd31, 32'hCAFEBABE);
        bus.rd_addr1 = 5'd31;
        bus.rd_addr2 = 5'd31;
        #1;
        checks++;
        if (bus.rd_data1 !== 32'hCAFEBABE) begin
            errors++;
            $display("FAIL dual_rd1: got %h want %h", bus.rd_data1, 32'hCAFEBABE);
        end
        checks++;
        if (bus.rd_data2 !== 32'hCAFEBABE) begin
            errors++;
            $display("FAIL dual_rd2: got %h want %h", bus.rd_data2, 32'hCAFEBABE);
        end
    endtask

    task automatic test_back_to_back();
        write_alu(5'd12, 32'h0000_1111);
        write_alu(5'd13, 32'h2222_0000);
        bus.wb_reg_write     = 1'b1;
        bus.wb_mem_reg       = 1'b1;
        bus.wb_read_data_mem = 32'h8000_0001;
        bus.wb_write_reg     = 5'd12;
        step();
        idle_inputs();
        bus.rd_addr1 = 5'd12;
        bus.rd_addr2 = 5'd13;
        #1;
        checks++;
        if (bus.rd_data1 !== 32'h8000_0001) begin
            errors++;
            $display("FAIL b2b_r12: got %h want %h", bus.rd_data1, 32'h8000_0001);
        end
        checks++;
        if (bus.rd_data2 !== 32'h2222_0000) begin
            errors++;
            $display("FAIL b2b_r13: got %h want %h", bus.rd_data2, 32'h2222_0000);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        idle_inputs();
        bus.rd_addr1 = 5'd0;
        bus.rd_addr2 = 5'd0;
        step();
        test_reset();
        test_wb_mux();
        test_zero_reg();
        test_same_cycle_rw();
        test_reset_collide();
        test_dual_port();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and architectural register file for the 5-stage MIPS pipeline. Consumes the registered outputs of the MEM/WB pipeline register and selects the writeback value: load data or ALU result. Writes that value into a 32×32-bit register file and serves the two combinational read ports used by the ID stage. Register $0 is hardwired to zero. An optional write-to-read bypass resolves the WB/ID structural hazard.

## Interface
Parameters:
- none; widths fixed at 32-bit data, 5-bit register index, 32 entries.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- wb_reg_write  in  1  write enable from MEM/WB.
- wb_mem_reg  in  1  1 = write back load data; 0 = write back ALU result.
- wb_read_data_mem  in  32  load data from MEM/WB.
- wb_alu_result  in  32  ALU result / address from MEM/WB.
- wb_write_reg  in  5  destination register index.
- rd_addr1  in  5  ID read port 1 index (rs).
- rd_addr2  in  5  ID read port 2 index (rt).
- rd_data1  out  32  read port 1 data.
- rd_data2  out  32  read port 2 data.
- wb_data  out  32  selected writeback value, combinational; also fed to the EX forwarding mux.
- wb_we  out  1  qualified write strobe: wb_reg_write && wb_write_reg != 0.

## Operation
- Writeback mux: wb_data = wb_mem_reg ? wb_read_data_mem : wb_alu_result. Pure combinational, full 32 bits, no sign or width manipulation.
- Write: on a rising edge with rst=0 and wb_we=1, regs[wb_write_reg] <= wb_data.
- $0: writes to index 0 are discarded. Reads of index 0 always return 32'h0, regardless of the stored value or the bypass.
- Reads: rd_dataN is combinational from regs[rd_addrN].
- Reset: on a rising edge with rst=1, all 32 entries are cleared to 32'h0 in that single cycle. A write presented in the same cycle is ignored, because reset has priority.
- Both read ports may address the same register; each returns the identical value.
- wb_reg_write=1 with wb_write_reg=0 is legal and behaves as a no-op; wb_we=0.

## Timing
- Write latency: 1 cycle. Data is visible at the read ports, without bypass, in the cycle after the write edge.
- Read latency: 0 cycles; combinational from address and state.
- Reset values:
  - rd_data1 = rd_data2 = 32'h0 after the reset edge.
  - wb_data and wb_we follow the inputs combinationally and have no reset value.
  - With upstream MEM/WB in reset, the inputs are zero, so wb_data=0 and wb_we=0.
- Reset mid-operation: a pending write in the reset cycle is lost. The first post-reset write occurs on the first edge with rst=0.
- Simultaneous read and write of the same non-zero index in the same cycle is handled as described under Configuration.

## Configuration
- Macro WB_BYPASS_EN.
- Defined: write-first bypass.
  - If wb_we=1 and rd_addrN == wb_write_reg != 0, then rd_dataN = wb_data in the same cycle.
  - rst=1 suppresses the bypass; rd_dataN then shows regs contents.
- Undefined: no bypass.
  - rd_dataN shows the old contents until the edge.
  - The hazard unit must stall ID for one cycle on a WB/ID index match.

## Test plan
1. Reset clears all entries:
   - Stimulus: write 32'hDEADBEEF to r5; assert rst for 1 cycle; read r5.
   - Required: rd_data1 = 32'h0.
2. Writeback mux and write:
   - Stimulus, cycle 1: wb_reg_write=1, wb_mem_reg=1, wb_read_data_mem=32'h1234_5678, wb_alu_result=32'hFFFF_0000, wb_write_reg=9.
   - Stimulus, cycle 2: same but wb_mem_reg=0 and wb_write_reg=10.
   - Required: wb_data is 32'h12345678 in cycle 1 and 32'hFFFF0000 in cycle 2; afterwards r9 = 32'h12345678 and r10 = 32'hFFFF0000.
3. $0 protection:
   - Stimulus: wb_reg_write=1, wb_write_reg=0, wb_alu_result=32'hA5A5A5A5.
   - Required: wb_we=0; rd_addr1=0 returns 32'h0 on the same cycle and the next, in both configurations.
4. Same-cycle read/write on r7, with r7 previously 32'h1 and new value 32'h2:
   - WB_BYPASS_EN defined: rd_data1 = 32'h2 in the same cycle.
   - WB_BYPASS_EN undefined: rd_data1 = 32'h1 in the same cycle and 32'h2 in the next cycle.
5. Reset collides with write:
   - Stimulus: rst=1 and wb_we=1 targeting r3 with 32'h77.
   - Required: r3 = 32'h0 afterwards; rd_data is 0 during that cycle even with WB_BYPASS_EN defined.
6. Dual port:
   - Stimulus: rd_addr1 = rd_addr2 = 31 after writing 32'hCAFEBABE to r31.
   - Required: both ports return 32'hCAFEBABE.
